// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the data memory responder: default geometry and
// timing, the responder state encoding, and the latched request record.
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int DMEM_DEPTH_DEF = 256;  // words in the data memory
    localparam int DMEM_WAIT_DEF  = 2;    // extra cycles per access (0-15)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Request captured in IDLE and used for the whole access.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Single-port DEPTH x 32 storage: synchronous write, combinational read.
// Contents are never reset.
// Ports:
//   clk      - clock; writes happen on its rising edge
//   i_we     - write enable
//   i_addr   - word index (shared by read and write)
//   i_wdata  - write data
//   o_rdata  - combinational read data at i_addr
// ----------------------------------------------------------------------------
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_memory_responder.sv
// ----------------------------------------------------------------------------
// data_memory_responder
// Multi-cycle data memory front end. A request seen in IDLE is latched, held
// for WAIT_STATES cycles, and completed with a one-cycle MemReady pulse in
// RESP. Out-of-range addresses and simultaneous read+write report MemError.
// Ports:
//   clk               - clock
//   Reset_n           - asynchronous active-low reset
//   Address_DataMem   - word address
//   WriteData_DataMem - store data
//   MemWrite/MemRead  - store / load request, held until MemReady
//   ReadData_DataMem  - registered load data, held until the next read
//   MemReady          - one-cycle completion pulse
//   MemError          - error flag, qualified by MemReady
// ----------------------------------------------------------------------------
module data_memory_responder
    import mips_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH_DEF,
    parameter int WAIT_STATES = DMEM_WAIT_DEF
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic [31:0] Address_DataMem,
    input  logic [31:0] WriteData_DataMem,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData_DataMem,
    output logic        MemReady,
    output logic        MemError
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS      = WAIT_STATES[3:0];
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    dmem_state_e r_state;
    logic [3:0]  r_cnt;
    dmem_req_t   r_req;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_error;

    dmem_req_t   w_cur;
    logic        w_enter_resp;
    logic        w_conflict;
    logic        w_oor;
    logic        w_we;
    logic [31:0] w_rdata;

    // With zero wait states the access completes on the sampling edge itself,
    // before the latch holds anything, so the live inputs are used in IDLE.
    assign w_cur = (r_state == ST_IDLE) ?
                   '{rd: MemRead, wr: MemWrite, addr: Address_DataMem, wdata: WriteData_DataMem} :
                   r_req;

    assign w_enter_resp = ((r_state == ST_IDLE) && (MemRead || MemWrite) && (WS == 4'd0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd1));

    assign w_conflict = w_cur.rd & w_cur.wr;
    assign w_oor      = (w_cur.addr >= DEPTH_W);
    assign w_we       = w_enter_resp & w_cur.wr & ~w_cur.rd & ~w_oor;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_cur.addr[AW-1:0]),
        .i_wdata (w_cur.wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_req   <= '0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (MemRead || MemWrite) begin
                        r_req <= w_cur;
                        if (WS == 4'd0) begin
                            r_state <= ST_RESP;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd1)
                        r_state <= ST_RESP;
                    r_cnt <= r_cnt - 4'd1;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_error <= w_conflict | w_oor;
                // Only a clean read touches the data register; an
                // out-of-range read returns zero, a conflict leaves it alone.
                if (w_cur.rd && !w_cur.wr)
                    r_rdata <= w_oor ? 32'd0 : w_rdata;
            end
        end
    end

    assign ReadData_DataMem = r_rdata;
    assign MemReady         = r_ready;
    assign MemError         = r_error;

endmodule
